fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the single-cycle, combinational-read instruction memory.
- Owns the PC and drives memory address/enable each cycle.
- Captures the returned 32-bit word into a 2-entry fetch queue.
- Presents {instr, pc} to decode over a valid/ready handshake; handles redirects from execute, halt requests and the end-of-run memory dump request.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_ALIGN_CHECK_EN adds a misalign flag to each queued entry.
package fetch_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          PC_W         = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_STEP  = 4;
  localparam int          DEF_QDEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic               misalign;
`endif
  } entry_t;

  function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer: power-of-two depth, push/pop/flush, flush wins.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  entry_t             mem [QDEPTH];
  logic [PTR_W-1:0]   hd_ptr;
  logic [PTR_W-1:0]   tl_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign full    = (cnt == CNT_W'(QDEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[hd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[tl_ptr] <= push_entry;
        tl_ptr      <= tl_ptr + PTR_W'(1);
      end
      if (do_pop) hd_ptr <= hd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational imem, queues
// {instr, pc} for decode; optional FETCH_ALIGN_CHECK_EN flags misaligned PCs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          QDEPTH   = DEF_QDEPTH,
  parameter int          PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  output logic        imem_enable,
  output logic        imem_wr,
  output logic [31:0] imem_data_in,
  output logic        imem_createdump,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        inst_misalign,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted
);

  state_e      state;
  logic [31:0] pc;

  entry_t q_in;
  entry_t q_head;
  logic   q_full;
  logic   q_empty;
  logic   q_pop;
  logic   redir;
  logic   can_fetch;
  logic   misal;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (can_fetch),
    .push_entry (q_in),
    .pop        (q_pop),
    .flush      (redir),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign inst_valid = !q_empty;
  assign q_pop      = inst_valid && inst_ready;
  assign redir      = redirect_valid && (state == FETCH || state == DRAIN);

  // halt_req suppresses the fetch in its own cycle so nothing past HALT is queued
  assign can_fetch  = (state == FETCH) && !redir && !halt_req && (!q_full || q_pop);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misal         = is_misaligned(pc);
  assign inst_misalign = inst_valid && q_head.misalign;
`else
  assign misal         = 1'b0;
`endif

  always_comb begin
    q_in       = '0;
    q_in.instr = misal ? '0 : imem_rdata;
    q_in.pc    = pc;
`ifdef FETCH_ALIGN_CHECK_EN
    q_in.misalign = misal;
`endif
  end

  // A misaligned fault entry is synthesized locally, so memory is not read for it
  assign imem_enable     = can_fetch && !misal;
  assign imem_addr       = pc;
  assign imem_wr         = 1'b0;
  assign imem_data_in    = '0;
  assign imem_createdump = (state == DRAIN) && q_empty && !redir;

  assign inst_data = inst_valid ? q_head.instr : '0;
  assign inst_pc   = inst_valid ? q_head.pc    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (redir) begin
            pc <= redirect_pc;
          end else if (halt_req) begin
            state <= DRAIN;
          end else if (can_fetch) begin
            if (misal) state <= DRAIN;
            else       pc    <= pc + 32'(PC_STEP);
          end
        end
        DRAIN: begin
          if (redir) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end else if (q_empty) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences
// for backpressure, halt/drain, async reset and the misaligned redirect.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [31:0] imem_data_in;
  logic        imem_createdump;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        inst_misalign;
`endif
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_enable     (imem_enable),
    .imem_wr         (imem_wr),
    .imem_data_in    (imem_data_in),
    .imem_createdump (imem_createdump),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .inst_misalign   (inst_misalign),
`endif
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1ns later, well before the next posedge
  task automatic drive(input logic s, input logic rdy, input logic hlt,
                       input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    start = s; inst_ready = rdy; halt_req = hlt;
    redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; inst_ready = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        start, ready, halt, rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc, e_data;
    logic        e_en;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[13];

  int          deliv;
  int          dumps;
  logic        en_seen;
  logic        dump_halted;
  logic [31:0] last_pc;

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h1111_1111, 1'b1, 32'h4};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h2222_2222, 1'b1, 32'h8};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC0DE_0008, 1'b1, 32'hC};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC0DE_0008, 1'b0, 32'h10};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h8,  32'hC0DE_0008, 1'b0, 32'h10};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 32'h40};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'hC0DE_0040, 1'b1, 32'h44};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h44, 32'hC0DE_0044, 1'b0, 32'h48};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 32'h80};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'hC0DE_0080, 1'b1, 32'h84};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h84, 32'hC0DE_0084, 1'b1, 32'h88};

    // Reset values
    #2;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_en", 32'(imem_enable), 32'h0);
    chk("rst_dump", 32'(imem_createdump), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wr", {imem_data_in[30:0], imem_wr}, 32'h0);
    do_reset();

    // Sequential fetch, backpressure, redirect while full, redirect beats halt
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].start, vt[i].ready, vt[i].halt, vt[i].rv, vt[i].rpc);
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_en", i), 32'(imem_enable), 32'(vt[i].e_en));
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_dump", i), {31'h0, imem_createdump | halted}, 32'h0);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), inst_pc, vt[i].e_pc);
        chk($sformatf("v%0d_data", i), inst_data, vt[i].e_data);
      end
    end

    // Redirect to a misaligned target
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_valid0", 32'(inst_valid), 32'h0);
    chk("mis_addr", imem_addr, 32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_en0", 32'(imem_enable), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_valid1", 32'(inst_valid), 32'h1);
    chk("mis_pc", inst_pc, 32'h42);
    chk("mis_data", inst_data, 32'h0);
    chk("mis_flag", 32'(inst_misalign), 32'h1);
    chk("mis_en1", 32'(imem_enable), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_valid2", 32'(inst_valid), 32'h0);
    chk("mis_dump", 32'(imem_createdump), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_halted", 32'(halted), 32'h1);
`else
    chk("mis_en0", 32'(imem_enable), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_pc", inst_pc, 32'h42);
    chk("mis_data", inst_data, 32'hC0DE_0042);
    chk("mis_next_addr", imem_addr, 32'h46);
`endif

    // Backpressure: ready low for 5 cycles after start, then in-order delivery
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bp_en", 32'(imem_enable), 32'h0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_valid", 32'(inst_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("bp_valid%0d", i), 32'(inst_valid), 32'h1);
      chk($sformatf("bp_pc%0d", i), inst_pc, 32'(4 * i));
    end

    // Halt with two queued entries: drain, single dump pulse, then stay halted
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("halt_en", 32'(imem_enable), 32'h0);
    chk("halt_head", inst_pc, 32'h0);
    deliv = inst_valid ? 1 : 0;
    dumps = 0; en_seen = 1'b0; dump_halted = 1'b0; last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (inst_valid) begin deliv++; last_pc = inst_pc; end
      if (imem_createdump) begin dumps++; dump_halted = halted; end
      en_seen = en_seen | imem_enable;
    end
    chk("halt_deliv", 32'(deliv), 32'h2);
    chk("halt_last_pc", last_pc, 32'h4);
    chk("halt_dumps", 32'(dumps), 32'h1);
    chk("halt_dump_pre", 32'(dump_halted), 32'h0);
    chk("halt_en_seen", 32'(en_seen), 32'h0);
    chk("halt_flag", 32'(halted), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_ignore", {imem_enable, inst_valid, halted}, 32'h1);
    chk("halt_ignore_addr", imem_addr, 32'h8);

    // Asynchronous reset between edges, then restart from RESET_PC
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", {28'h0, inst_valid, imem_enable, imem_createdump, halted}, 32'h0);
    chk("arst_data", inst_data, 32'h0);
    chk("arst_pc", inst_pc, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("arst_en", 32'(imem_enable), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("arst_first_pc", inst_pc, 32'h0);
    chk("arst_first_data", inst_data, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
